beam_sched: RTL
===============

# beam_sched

Burst scheduler that sequences the beam mux. It holds a small programmable table of {DAC index, burst length} entries and walks it on command. For each entry it drives the mux's DAC select and a source-gate enable, then counts accepted source beats. It cross-checks the source's tlast against the programmed length and advances to the next entry at each burst boundary, optionally looping. It sits beside the beam mux, upstream of its select input, and observes the source AXI-Stream handshake.

## Interface
- DEPTH, 8, number of schedule entries (power of two, ≥2); AW = clog2(DEPTH)
- LEN_W, 16, width of burst length field
- i_clk  in  1  single clock, all logic rising-edge
- i_rst  in  1  synchronous, active-high reset
- i_cfg_we  in  1  write schedule entry (ignored while o_busy=1)
- i_cfg_addr  in  AW  entry address
- i_cfg_dac  in  2  DAC index for entry (0..2 valid; 3 invalid)
- i_cfg_len  in  LEN_W  burst length in beats; 0 = end-of-schedule marker
- i_start  in  1  start pulse (ignored while busy)
- i_loop  in  1  sampled at start: wrap to entry 0 after last entry
- i_abort  in  1  stop immediately
- i_beat  in  1  source tvalid & tready
- i_last  in  1  source tlast (qualified by i_beat)
- o_dac_sel  out  2  select to beam mux
- o_gate  out  1  source may present data
- o_busy  out  1  schedule running
- o_done  out  1  one-cycle pulse at normal completion
- o_entry  out  AW  index of current entry
- o_len_err  out  1  sticky: tlast/length mismatch
- o_sel_err  out  1  sticky: entry with DAC index 3 encountered
- o_stray_err  out  1  sticky: beat seen outside RUN

## Operation
- Table: DEPTH registers {dac[1:0], len[LEN_W-1:0]}. Reset clears all len to 0 and all dac to 0.
- States: IDLE, FETCH, RUN.
- IDLE: o_busy=0, o_gate=0. On i_start: clear all three error flags, latch loop, go to FETCH with o_entry=0.
- FETCH (o_gate=0, o_busy=1): read entry o_entry.
  - If len==0: end of schedule. With loop latched and o_entry≠0, set o_entry=0 and stay in FETCH. Otherwise pulse o_done and go to IDLE. Entry 0 with len 0 always completes.
  - If dac==3: set o_sel_err, skip the entry (same advance rule as end of burst).
  - Otherwise load o_dac_sel=dac, clear beat counter, go to RUN.
- RUN (o_gate=1): each i_beat increments the counter (LEN_W bits).
  - Final beat is the one where count==len-1.
  - i_last on a non-final beat sets o_len_err without terminating the burst.
  - A final beat without i_last also sets o_len_err. Length is authoritative.
  - On the final beat, advance.
- Advance: if o_entry==DEPTH-1, treat as end of schedule (wrap to 0 if loop, else o_done and IDLE); otherwise o_entry+1, go to FETCH.
- i_beat while not in RUN sets o_stray_err; the beat is not counted.
- i_abort (any state, priority over everything except reset): next cycle IDLE, o_gate=0, no o_done, o_dac_sel holds, errors hold.
- i_start with i_abort in the same cycle: abort wins, stay IDLE.
- o_dac_sel holds its last value in IDLE and FETCH. It changes only on the FETCH→RUN transition, so it never changes while o_gate=1.

## Timing
- Reset values: o_dac_sel=0, o_gate=0, o_busy=0, o_done=0, o_entry=0, all error flags 0, state IDLE.
- All outputs are registered.
- i_start at cycle t: FETCH at t+1 (o_busy=1), RUN at t+2 (o_gate=1, o_dac_sel valid).
- Final beat at cycle t: o_gate=0 at t+1 (FETCH), next burst gate high at t+2. The inter-burst gap is exactly one cycle.
- Completion: o_done is high for one cycle, at the cycle after FETCH sees len==0. IDLE follows (o_busy=0) in the same cycle o_done is visible.
- The beat counter never wraps within a legal burst; len=2^LEN_W-1 is the maximum.

## Test plan
- Program {0:dac1,len4},{1:dac2,len2},{2:len0}; start, source sends 4 beats (tlast on beat 4) then 2 beats (tlast on beat 2) -> o_dac_sel=1 for 4 beats, gate low 1 cycle, o_dac_sel=2 for 2 beats, o_done pulse, no errors.
- Same table, tlast on beat 2 of the first burst -> o_len_err=1, burst still ends after beat 4, schedule completes normally.
- Table {0:dac0,len3},{1:dac3,len5},{2:dac1,len1},{3:len0} -> o_sel_err=1, entry 1 skipped, 3 beats on DAC0 then 1 beat on DAC1, o_done.
- Loop=1 with 2-entry table {0:dac2,len2},{1:len0} -> repeats DAC2 bursts indefinitely, no o_done. i_abort mid-burst -> o_gate=0 and o_busy=0 next cycle.
- Full table of DEPTH entries, all len≠0 -> after entry DEPTH-1 the schedule ends with o_done. Cfg writes during the run are ignored (verify by rerunning). A beat in IDLE sets o_stray_err. Reset mid-RUN returns all outputs to reset values.

Source files
------------

// File: rtl/beam_sched.sv
// Burst scheduler for the beam mux: walks a programmable {dac, len} table,
// gating the source and counting accepted beats per entry.
module beam_sched #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LEN_W = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_we,
  input  logic [AW-1:0]    i_cfg_addr,
  input  logic [1:0]       i_cfg_dac,
  input  logic [LEN_W-1:0] i_cfg_len,
  input  logic             i_start,
  input  logic             i_loop,
  input  logic             i_abort,
  input  logic             i_beat,
  input  logic             i_last,
  output logic [1:0]       o_dac_sel,
  output logic             o_gate,
  output logic             o_busy,
  output logic             o_done,
  output logic [AW-1:0]    o_entry,
  output logic             o_len_err,
  output logic             o_sel_err,
  output logic             o_stray_err
);

  typedef enum logic [1:0] {StIdle, StFetch, StRun} state_e;

  state_e           state_q;
  logic [1:0]       tbl_dac [DEPTH];
  logic [LEN_W-1:0] tbl_len [DEPTH];
  logic [LEN_W-1:0] cnt_q;
  logic             loop_q;

  logic [1:0]       cur_dac;
  logic [LEN_W-1:0] cur_len;
  logic             final_beat;
  logic             adv_finish;
  logic [AW-1:0]    adv_entry;

  always_comb begin
    cur_dac    = tbl_dac[o_entry];
    cur_len    = tbl_len[o_entry];
    final_beat = (cnt_q == cur_len - LEN_W'(1));
    // Leaving the last table slot behaves like hitting an end marker.
    adv_finish = (o_entry == AW'(DEPTH - 1)) && !loop_q;
    adv_entry  = (o_entry == AW'(DEPTH - 1)) ? '0 : o_entry + AW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      loop_q      <= 1'b0;
      o_dac_sel   <= 2'd0;
      o_gate      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_entry     <= '0;
      o_len_err   <= 1'b0;
      o_sel_err   <= 1'b0;
      o_stray_err <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_dac[i] <= 2'd0;
        tbl_len[i] <= '0;
      end
    end else begin
      o_done <= 1'b0;
      if (i_cfg_we && !o_busy) begin
        tbl_dac[i_cfg_addr] <= i_cfg_dac;
        tbl_len[i_cfg_addr] <= i_cfg_len;
      end
      if (i_beat && state_q != StRun) o_stray_err <= 1'b1;

      if (i_abort) begin
        state_q <= StIdle;
        o_gate  <= 1'b0;
        o_busy  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_start) begin
              o_len_err   <= 1'b0;
              o_sel_err   <= 1'b0;
              o_stray_err <= 1'b0;
              loop_q      <= i_loop;
              o_entry     <= '0;
              o_busy      <= 1'b1;
              state_q     <= StFetch;
            end
          end
          StFetch: begin
            if (cur_len == '0) begin
              if (loop_q && o_entry != '0) begin
                o_entry <= '0;
              end else begin
                o_done  <= 1'b1;
                o_busy  <= 1'b0;
                state_q <= StIdle;
              end
            end else if (cur_dac == 2'd3) begin
              o_sel_err <= 1'b1;
              if (adv_finish) begin
                o_done  <= 1'b1;
                o_busy  <= 1'b0;
                state_q <= StIdle;
              end else begin
                o_entry <= adv_entry;
              end
            end else begin
              o_dac_sel <= cur_dac;
              cnt_q     <= '0;
              o_gate    <= 1'b1;
              state_q   <= StRun;
            end
          end
          StRun: begin
            if (i_beat) begin
              cnt_q <= cnt_q + LEN_W'(1);
              if (final_beat) begin
                if (!i_last) o_len_err <= 1'b1;
                o_gate <= 1'b0;
                if (adv_finish) begin
                  o_done  <= 1'b1;
                  o_busy  <= 1'b0;
                  state_q <= StIdle;
                end else begin
                  o_entry <= adv_entry;
                  state_q <= StFetch;
                end
              end else if (i_last) begin
                o_len_err <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
